// File: rtl/key_cmd_scheduler.sv
// Maps PS/2 key events to game commands, adds auto-repeat for a held direction
// key, and queues commands in an 8-entry show-ahead FIFO with valid/ready output.
module key_cmd_scheduler #(
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    output logic         cmd_valid,
    output logic [2:0]   cmd_code,
    output logic         cmd_press,
    output logic         cmd_repeat,
    input  logic         cmd_ready,
    output logic [3:0]   fifo_count,
    output logic         overflow,
    input  logic         ovf_clr
);

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned FCNT_W = 4;
    localparam int unsigned ENT_W  = 5;

    typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

    rpt_state_t         state;
    logic [CNT_W-1:0]   counter;
    logic [1:0]         held_dir;
    logic               rpt_pend;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               mapped_c;
    logic [2:0]         map_code_c;

    // Fixed key map: W/A/S/D and arrows to directions, space and enter to FIRE/PAUSE
    always_comb begin
        mapped_c   = 1'b1;
        map_code_c = 3'd0;
        case (last_change)
            9'h01D, 9'h175: map_code_c = 3'd0;
            9'h01C, 9'h16B: map_code_c = 3'd1;
            9'h01B, 9'h172: map_code_c = 3'd2;
            9'h023, 9'h174: map_code_c = 3'd3;
            9'h029:         map_code_c = 3'd4;
            9'h05A:         map_code_c = 3'd5;
            default:        mapped_c   = 1'b0;
        endcase
    end

    logic             kb_ev_c, kb_press_c, is_dir_c, dir_press_c, held_rel_c;
    logic             expire_c, rpt_req_c, rpt_wr_c, push_c, pop_c, full_c;
    logic             push_ok_c, kb_drop_c;
    logic [ENT_W-1:0] push_data_c, head_next_c;
    logic [FCNT_W-1:0] count_after_pop_c, count_next_c;
    logic [PTR_W-1:0] rd_ptr_next_c;

    assign kb_ev_c     = key_valid & en & mapped_c;
    assign kb_press_c  = key_down[last_change];
    assign is_dir_c    = ~map_code_c[2];
    assign dir_press_c = kb_ev_c & kb_press_c & is_dir_c;
    assign held_rel_c  = kb_ev_c & ~kb_press_c & is_dir_c & (state != IDLE)
                       & (map_code_c[1:0] == held_dir);

    // An expiry is usable in its own cycle; rpt_pend only carries it past a keyboard write
    assign expire_c  = ((state == DELAY) && (counter == CNT_W'(REPEAT_DELAY - 1)))
                     | ((state == RPT)   && (counter == CNT_W'(REPEAT_PERIOD - 1)));
    assign rpt_req_c = en & (rpt_pend | expire_c) & ~dir_press_c & ~held_rel_c;
    assign rpt_wr_c  = rpt_req_c & ~kb_ev_c;

    assign push_c      = kb_ev_c | rpt_wr_c;
    assign push_data_c = kb_ev_c ? {1'b0, kb_press_c, map_code_c}
                                 : {1'b1, 1'b1, 1'b0, held_dir};
    assign pop_c       = cmd_valid & cmd_ready;
    assign full_c      = (fifo_count == FCNT_W'(DEPTH));
    assign push_ok_c   = push_c & (~full_c | pop_c);
    assign kb_drop_c   = kb_ev_c & full_c & ~pop_c;

    assign count_after_pop_c = fifo_count - FCNT_W'(pop_c);
    assign count_next_c      = count_after_pop_c + FCNT_W'(push_ok_c);
    assign rd_ptr_next_c     = rd_ptr + PTR_W'(pop_c);
    assign head_next_c       = (push_ok_c && (count_after_pop_c == '0)) ? push_data_c
                                                                        : mem[rd_ptr_next_c];

    // Repeat FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            counter  <= '0;
            held_dir <= 2'd0;
            rpt_pend <= 1'b0;
        end else if (!en) begin
            state    <= IDLE;
            counter  <= '0;
            rpt_pend <= 1'b0;
        end else if (dir_press_c) begin
            state    <= DELAY;
            counter  <= '0;
            held_dir <= map_code_c[1:0];
            rpt_pend <= 1'b0;
        end else if (held_rel_c) begin
            state    <= IDLE;
            counter  <= '0;
            rpt_pend <= 1'b0;
        end else begin
            rpt_pend <= rpt_req_c & kb_ev_c;
            case (state)
                DELAY: begin
                    if (counter == CNT_W'(REPEAT_DELAY - 1)) begin
                        counter <= '0;
                        state   <= RPT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                RPT: begin
                    if (counter == CNT_W'(REPEAT_PERIOD - 1)) counter <= '0;
                    else                                       counter <= counter + CNT_W'(1);
                end
                default: counter <= '0;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= push_data_c;
    end

    // FIFO control; head registers hold their value while empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 3'd0;
            cmd_press  <= 1'b0;
            cmd_repeat <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr     <= rd_ptr_next_c;
            fifo_count <= count_next_c;
            cmd_valid  <= (count_next_c != '0);
            if (count_next_c != '0) {cmd_repeat, cmd_press, cmd_code} <= head_next_c;
            if (kb_drop_c)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with short repeat timing (delay 10, period 4).
module tb_key_cmd_scheduler;

    localparam logic [8:0] K_W     = 9'h01D;
    localparam logic [8:0] K_A     = 9'h01C;
    localparam logic [8:0] K_D     = 9'h023;
    localparam logic [8:0] K_LEFT  = 9'h16B;
    localparam logic [8:0] K_FIRE  = 9'h029;
    localparam logic [8:0] K_PAUSE = 9'h05A;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic         cmd_press;
    logic         cmd_repeat;
    logic         cmd_ready;
    logic [3:0]   fifo_count;
    logic         overflow;
    logic         ovf_clr;

    int checks = 0;
    int errors = 0;
    int unsigned ncyc = 0;

    logic [4:0]  log_q [$];
    int unsigned log_t [$];

    key_cmd_scheduler #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .key_valid(key_valid),
        .last_change(last_change), .key_down(key_down),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_press(cmd_press),
        .cmd_repeat(cmd_repeat), .cmd_ready(cmd_ready), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Record every consumed entry as {repeat, press, code} with its cycle stamp
    always @(negedge clk) begin
        #1;
        if (cmd_valid && cmd_ready) begin
            log_q.push_back({cmd_repeat, cmd_press, cmd_code});
            log_t.push_back(ncyc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one decoder event at the next falling edge; returns when its entry is visible
    task automatic key_event(input logic [8:0] code, input logic press);
        @(negedge clk);
        key_valid         = 1'b1;
        last_change       = code;
        key_down[code]    = press;
        @(negedge clk);
        key_valid         = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count, overflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b c=%0d p=%0b r=%0b n=%0d o=%0b exp all 0",
                     cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count, overflow);
        end
    endtask

    task automatic test_basic();
        cmd_ready = 1'b0;
        key_event(K_W, 1'b1);
        checks++;
        if ({cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count} !== {1'b1, 3'd0, 1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL basic_push got v=%0b c=%0d p=%0b r=%0b n=%0d exp v=1 c=0 p=1 r=0 n=1",
                     cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count);
        end
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_valid, fifo_count, cmd_code, cmd_press} !== {1'b0, 4'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL basic_pop got v=%0b n=%0d c=%0d p=%0b exp v=0 n=0 c=0 p=1 (held)",
                     cmd_valid, fifo_count, cmd_code, cmd_press);
        end
        key_event(K_W, 1'b0);
        checks++;
        if ({cmd_valid, cmd_code, cmd_press, cmd_repeat} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_release got v=%0b c=%0d p=%0b r=%0b exp v=1 c=0 p=0 r=0",
                     cmd_valid, cmd_code, cmd_press, cmd_repeat);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty got v=%0b exp 0", cmd_valid);
        end
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        for (int i = 0; i < 9; i++) key_event((i % 2 == 1) ? K_PAUSE : K_FIRE, 1'b1);
        checks++;
        if ({fifo_count, overflow, cmd_valid, cmd_code} !== {4'd8, 1'b1, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL ovf_full got n=%0d o=%0b v=%0b c=%0d exp n=8 o=1 v=1 c=4",
                     fifo_count, overflow, cmd_valid, cmd_code);
        end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %0b exp 0", overflow);
        end
        @(negedge clk);
        ovf_clr = 1'b1; key_valid = 1'b1; last_change = K_FIRE;
        @(negedge clk);
        ovf_clr = 1'b0; key_valid = 1'b0;
        checks++;
        if ({overflow, fifo_count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL ovf_set_wins got o=%0b n=%0d exp o=1 n=8", overflow, fifo_count);
        end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        log_q.delete(); log_t.delete();
        cmd_ready = 1'b1;
        wait_cyc(12);
        checks++;
        if (log_q.size() != 8 || cmd_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain got entries=%0d v=%0b n=%0d o=%0b exp entries=8 v=0 n=0 o=0",
                     log_q.size(), cmd_valid, fifo_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i] !== ((i % 2 == 1) ? 5'b01101 : 5'b01100)) begin
                    errors++;
                    $display("FAIL ovf_order[%0d] got %b exp %b", i, log_q[i],
                             (i % 2 == 1) ? 5'b01101 : 5'b01100);
                end
            end
        end
        key_down[K_FIRE] = 1'b0;
        key_down[K_PAUSE] = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [4:0] exp_e [0:8];
        exp_e = '{5'b00100, 5'b01100, 5'b00101, 5'b01101,
                  5'b00100, 5'b01100, 5'b00101, 5'b01101, 5'b00100};
        cmd_ready = 1'b0;
        log_q.delete(); log_t.delete();
        for (int i = 0; i < 8; i++) key_event(((i / 2) % 2 == 1) ? K_PAUSE : K_FIRE, 1'(i % 2));
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL fpp_fill got n=%0d exp 8", fifo_count);
        end
        @(negedge clk);
        cmd_ready = 1'b1; key_valid = 1'b1; last_change = K_FIRE; key_down[K_FIRE] = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL fpp_count got n=%0d o=%0b exp n=8 o=0", fifo_count, overflow);
        end
        wait_cyc(12);
        checks++;
        if (log_q.size() != 9 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL fpp_drain got entries=%0d n=%0d exp entries=9 n=0", log_q.size(), fifo_count);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i] !== exp_e[i]) begin
                    errors++;
                    $display("FAIL fpp_order[%0d] got %b exp %b", i, log_q[i], exp_e[i]);
                end
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [4:0] exp_e [0:4];
        int unsigned exp_dt [0:4];
        exp_e  = '{5'b01011, 5'b11011, 5'b11011, 5'b11011, 5'b00011};
        exp_dt = '{0, 10, 14, 18, 20};
        cmd_ready = 1'b1;
        log_q.delete(); log_t.delete();
        key_event(K_D, 1'b1);
        wait_cyc(18);
        key_event(K_D, 1'b0);
        wait_cyc(15);
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL hold_count got %0d exp 5", log_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i] !== exp_e[i] || log_t[i] - log_t[0] != exp_dt[i]) begin
                    errors++;
                    $display("FAIL hold_entry[%0d] got %b @%0d exp %b @%0d", i, log_q[i],
                             log_t[i] - log_t[0], exp_e[i], exp_dt[i]);
                end
            end
        end
    endtask

    task automatic test_fire_collision();
        logic [4:0] exp_e [0:4];
        int unsigned exp_dt [0:4];
        exp_e  = '{5'b01011, 5'b01100, 5'b11011, 5'b00011, 5'b00100};
        exp_dt = '{0, 10, 11, 13, 15};
        cmd_ready = 1'b1;
        log_q.delete(); log_t.delete();
        key_event(K_D, 1'b1);
        wait_cyc(8);
        key_event(K_FIRE, 1'b1);
        wait_cyc(1);
        key_event(K_D, 1'b0);
        key_event(K_FIRE, 1'b0);
        wait_cyc(12);
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL fire_count got %0d exp 5", log_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i] !== exp_e[i] || log_t[i] - log_t[0] != exp_dt[i]) begin
                    errors++;
                    $display("FAIL fire_entry[%0d] got %b @%0d exp %b @%0d", i, log_q[i],
                             log_t[i] - log_t[0], exp_e[i], exp_dt[i]);
                end
            end
        end
    endtask

    task automatic test_dir_switch();
        logic [4:0] exp_e [0:5];
        int unsigned exp_dt [0:5];
        exp_e  = '{5'b01001, 5'b01000, 5'b00001, 5'b11000, 5'b11000, 5'b00000};
        exp_dt = '{0, 4, 7, 14, 18, 21};
        cmd_ready = 1'b1;
        log_q.delete(); log_t.delete();
        key_event(K_LEFT, 1'b1);
        wait_cyc(2);
        key_event(K_W, 1'b1);
        wait_cyc(1);
        key_event(K_LEFT, 1'b0);
        wait_cyc(12);
        key_event(K_W, 1'b0);
        wait_cyc(12);
        checks++;
        if (log_q.size() != 6) begin
            errors++;
            $display("FAIL switch_count got %0d exp 6", log_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i] !== exp_e[i] || log_t[i] - log_t[0] != exp_dt[i]) begin
                    errors++;
                    $display("FAIL switch_entry[%0d] got %b @%0d exp %b @%0d", i, log_q[i],
                             log_t[i] - log_t[0], exp_e[i], exp_dt[i]);
                end
            end
        end
    endtask

    task automatic test_enable();
        cmd_ready = 1'b1;
        log_q.delete(); log_t.delete();
        key_event(K_D, 1'b1);
        wait_cyc(3);
        en = 1'b0;
        key_event(K_FIRE, 1'b1);
        wait_cyc(10);
        key_down[K_FIRE] = 1'b0;
        en = 1'b1;
        wait_cyc(20);
        checks++;
        if (log_q.size() != 1 || (log_q.size() > 0 && log_q[0] !== 5'b01011)) begin
            errors++;
            $display("FAIL en_hold got entries=%0d first=%b exp entries=1 first=01011",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 5'b0);
        end
        key_event(K_D, 1'b0);
        wait_cyc(2);
        checks++;
        if (log_q.size() != 2 || (log_q.size() > 1 && log_q[1] !== 5'b00011)) begin
            errors++;
            $display("FAIL en_release got entries=%0d exp 2 ending 00011", log_q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        cmd_ready = 1'b0;
        key_event(K_A, 1'b1);
        key_event(K_FIRE, 1'b1);
        key_event(K_PAUSE, 1'b1);
        checks++;
        if ({fifo_count, cmd_valid, cmd_code} !== {4'd3, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL rstmid_fill got n=%0d v=%0b c=%0d exp n=3 v=1 c=1",
                     fifo_count, cmd_valid, cmd_code);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count, overflow} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_async got v=%0b c=%0d p=%0b r=%0b n=%0d o=%0b exp all 0",
                     cmd_valid, cmd_code, cmd_press, cmd_repeat, fifo_count, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(25);
        checks++;
        if ({fifo_count, cmd_valid} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_norepeat got n=%0d v=%0b exp n=0 v=0", fifo_count, cmd_valid);
        end
        key_down = '0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; key_valid = 1'b0; last_change = 9'd0;
        key_down = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;
        wait_cyc(2);
        test_reset();
        rst = 1'b1;
        wait_cyc(1);
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_hold_repeat();
        test_fire_collision();
        test_dir_switch();
        test_enable();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
Name: key_cmd_scheduler

Overview:
Sits between the PS/2 keyboard decoder and the game-control FSM. It maps raw key events (last_change, key_down, key_valid) to 3-bit game commands and generates auto-repeat for a held direction key. Commands are buffered in an 8-entry FIFO and delivered through a valid/ready handshake, so the game logic can consume them at its own pace.

Parameters:
REPEAT_DELAY, 25000000, cycles a direction key is held before the first repeat event.
REPEAT_PERIOD, 5000000, cycles between subsequent repeat events.
CNT_W, 26, width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
en  in  1  1 = accept key events; 0 = discard events and clear the repeat FSM
key_valid  in  1  one-cycle pulse from the keyboard decoder
last_change  in  9  {extend, scan code} of the event
key_down  in  512  decoder key-state vector, already updated in the key_valid cycle
cmd_valid  out  1  FIFO head is valid
cmd_code  out  3  0 UP, 1 LEFT, 2 DOWN, 3 RIGHT, 4 FIRE, 5 PAUSE
cmd_press  out  1  1 = press or repeat, 0 = release
cmd_repeat  out  1  1 = auto-repeat event
cmd_ready  in  1  consumer accepts the head entry when cmd_valid && cmd_ready
fifo_count  out  4  occupancy, 0..8
overflow  out  1  sticky: a keyboard event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, cmd_valid=0, cmd_code=0, cmd_press=0, cmd_repeat=0, fifo_count=0, overflow=0, repeat FSM in IDLE, counter=0.
- Key map (fixed, 9-bit codes):
  - 0x01D→UP, 0x01C→LEFT, 0x01B→DOWN, 0x023→RIGHT (W/A/S/D)
  - 0x175→UP, 0x16B→LEFT, 0x172→DOWN, 0x174→RIGHT (arrow keys)
  - 0x029→FIRE, 0x05A→PAUSE
  - Any other code is ignored.
- Keyboard event: in a cycle t with key_valid=1, en=1 and a mapped code, press = key_down[last_change]. The entry {repeat=0, press, code} is written at the edge ending cycle t.
- FIFO:
  - 8 entries × 5 bits, show-ahead; head drives cmd_* outputs.
  - If the FIFO was empty, cmd_valid=1 from cycle t+1.
  - Pop on cmd_valid && cmd_ready.
  - Push and pop in the same cycle is legal when full or empty-with-push-bypass-not-required; fifo_count is unchanged.
  - Pointers wrap modulo 8.
  - cmd_code, cmd_press and cmd_repeat hold their last value while cmd_valid=0.
- Full FIFO:
  - A keyboard push while full and no simultaneous pop is dropped and sets overflow.
  - A repeat push while full is dropped silently.
  - ovf_clr=1 clears overflow; a new overflow in the same cycle wins, so overflow stays 1.
- Repeat FSM (states IDLE, DELAY, RPT; tracks held_dir[1:0]):
  - IDLE → DELAY on an accepted direction press: held_dir = code, counter = 0.
  - DELAY: counter++. When counter = REPEAT_DELAY-1, raise rpt_pend, counter = 0, go to RPT.
  - RPT: counter++. When counter = REPEAT_PERIOD-1, raise rpt_pend, counter = 0.
  - A new direction press in DELAY or RPT restarts DELAY with the new held_dir and clears rpt_pend.
  - A release of held_dir → IDLE and clears rpt_pend. Release of another direction has no FSM effect; the release event is still queued.
  - FIRE and PAUSE never affect the FSM.
  - en=0 → IDLE, rpt_pend cleared, incoming events discarded. The FIFO keeps draining.
- Single write port:
  - Keyboard event has priority. rpt_pend is written ({1,1,held_dir}) on the first cycle with no keyboard write, then cleared.
  - A pending repeat is superseded, not duplicated, if the next period expires first.
- Widths: counter is CNT_W bits and never wraps before its compare value.

Test Plan:
- Press W (key_valid, 0x01D, key_down[0x01D]=1) into an empty FIFO → next cycle cmd_valid=1, cmd_code=0, cmd_press=1, cmd_repeat=0, fifo_count=1; cmd_ready=1 → fifo_count=0, cmd_valid=0.
- REPEAT_DELAY=10, REPEAT_PERIOD=4; hold D with cmd_ready=1 → repeat entries (code 3, repeat=1) written 10, 14, 18 cycles after the press write; release → a release entry is queued and no further repeats occur.
- cmd_ready=0; 9 mapped press events → fifo_count=8, overflow=1, and the 9th event is absent after draining; ovf_clr → overflow=0.
- Full FIFO with a simultaneous push and cmd_ready=1 → fifo_count stays 8, overflow stays 0, and order is preserved.
- Repeat expiry in the same cycle as a FIRE press → FIRE is written in that cycle and the repeat entry one cycle later.
- Hold LEFT, press UP, then release LEFT → repeats switch to code 0, and the LEFT release does not stop them.
- en=0 during a hold → no entries are written and the FSM returns to IDLE.
- Assert rst mid-hold with 3 entries queued → all outputs at reset values immediately, and no repeat after rst is released.
